// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SEND,
      ACK,
      WAIT_IDLE,
      ERROR
   } tx_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_FALL = 10;
   localparam int ACK_FALL  = 11;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stable-count glitch filter for one PS/2 line.
module ps2_line_filter #(
   parameter int FILTER_MAX = 19
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filtered
);

   localparam int CW = $clog2(FILTER_MAX + 2);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments only; lines reset to the idle-high level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync     <= 2'b11;
         cnt      <= '0;
         filtered <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == filtered) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_MAX)) begin
            filtered <= sync[1];
            cnt      <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame, device ack.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int FILTER_MAX     = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   tx_state_e              state, state_next;
   logic                   clk_f, data_f, clk_f_q, fall;
   logic [DATA_BITS+1:0]   shift;
   logic [3:0]             edge_cnt;
   logic [IW-1:0]          inh_cnt;
   logic [TW-1:0]          to_cnt;
   logic                   data_q;
   logic                   inh_done, timed_out;

   ps2_line_filter #(.FILTER_MAX(FILTER_MAX)) u_clk_filter (
      .clk(clk), .rst(rst), .raw(ps2_clk_in), .filtered(clk_f)
   );

   ps2_line_filter #(.FILTER_MAX(FILTER_MAX)) u_data_filter (
      .clk(clk), .rst(rst), .raw(ps2_data_in), .filtered(data_f)
   );

   assign fall      = clk_f_q & ~clk_f;
   assign inh_done  = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
   assign timed_out = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (tx_valid) state_next = INHIBIT;
         INHIBIT:   if (inh_done) state_next = START;
         START:     state_next = SEND;
         SEND: begin
            if (timed_out)                                      state_next = ERROR;
            else if (fall && edge_cnt == 4'(STOP_FALL - 1))     state_next = ACK;
         end
         ACK: begin
            if (timed_out)                                      state_next = ERROR;
            else if (fall && edge_cnt == 4'(ACK_FALL - 1))      state_next = data_f ? ERROR : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (clk_f && data_f) state_next = IDLE;
            else if (timed_out)  state_next = ERROR;
         end
         ERROR:     state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Start bit stays asserted after clock release until the device's first falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_f_q  <= 1'b1;
         shift    <= '0;
         edge_cnt <= '0;
         inh_cnt  <= '0;
         to_cnt   <= '0;
         data_q   <= 1'b0;
      end else begin
         clk_f_q <= clk_f;
         unique case (state)
            IDLE: begin
               if (tx_valid) begin
                  shift   <= {1'b1, ~^tx_data, tx_data};
                  inh_cnt <= '0;
               end
            end
            INHIBIT: inh_cnt <= inh_cnt + IW'(1);
            START: begin
               edge_cnt <= '0;
               to_cnt   <= '0;
               data_q   <= 1'b1;
            end
            SEND: begin
               to_cnt <= to_cnt + TW'(1);
               if (fall) begin
                  edge_cnt <= edge_cnt + 4'd1;
                  if (edge_cnt < 4'(STOP_FALL - 1)) begin
                     data_q <= ~shift[0];
                     shift  <= shift >> 1;
                  end else begin
                     data_q <= 1'b0;
                  end
               end
            end
            ACK: begin
               to_cnt <= to_cnt + TW'(1);
               if (fall) edge_cnt <= edge_cnt + 4'd1;
            end
            WAIT_IDLE: to_cnt <= to_cnt + TW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: pad drives are decoded from state, so an async reset releases the bus without a clock edge.
   always_comb begin
      ps2_clk_drive_low  = 1'b0;
      ps2_data_drive_low = 1'b0;
      tx_ready           = 1'b0;
      tx_done            = 1'b0;
      tx_error           = 1'b0;
      rx_inhibit         = 1'b1;
      unique case (state)
         IDLE: begin
            tx_ready   = 1'b1;
            rx_inhibit = 1'b0;
         end
         INHIBIT:   ps2_clk_drive_low = 1'b1;
         START: begin
            ps2_clk_drive_low  = 1'b1;
            ps2_data_drive_low = 1'b1;
         end
         SEND:      ps2_data_drive_low = data_q;
         WAIT_IDLE: tx_done = clk_f & data_f;
         ERROR:     tx_error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a PS/2 device model on open-drain lines.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH      = 40;
   localparam int TO       = 3000;
   localparam int FM       = 3;
   localparam int HALF     = 40;
   localparam int QTR      = 20;
   localparam int WAIT_MAX = 6000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_drive_low, ps2_data_drive_low;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_error, rx_inhibit;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [7:0] frame_q[$];
   bit         done_q[$];

   assign ps2_clk_in  = dev_clk  & ~ps2_clk_drive_low;
   assign ps2_data_in = dev_data & ~ps2_data_drive_low;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .FILTER_MAX(FM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_drive_low(ps2_clk_drive_low),
      .ps2_data_drive_low(ps2_data_drive_low),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_done(tx_done),
      .tx_error(tx_error),
      .rx_inhibit(rx_inhibit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Outcome scoreboard: every done/error pulse must match the next queued expectation.
   always @(negedge clk) begin : outcome_mon
      bit exp_done;
      if (!rst && (tx_done || tx_error)) begin
         if (done_q.size() == 0) begin
            check("unexpected_pulse", 32'({tx_done, tx_error}), 0);
         end else begin
            exp_done = done_q.pop_front();
            check("outcome", 32'({tx_done, tx_error}), exp_done ? 32'h2 : 32'h1);
         end
      end
   end

   // outcome: 1 = expect tx_done, 0 = expect tx_error, -1 = no pulse expected
   task automatic request(input logic [7:0] b, input int outcome, input bit keep);
      int t = 0;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      frame_q.push_back(b);
      if (outcome >= 0) done_q.push_back(outcome == 1);
      while (!tx_ready && t < WAIT_MAX) begin
         @(negedge clk);
         t++;
      end
      check("accept_ready", 32'(tx_ready), 1);
      @(posedge clk);
      #1;
      if (!keep) tx_valid = 1'b0;
   endtask

   task automatic device(input bit ack, input bit silent, input int abort_fall);
      int          t = 0;
      int          inh = 0;
      int          c0;
      logic [10:0] got;
      logic [7:0]  d;
      logic        exp_par;
      @(negedge clk);
      while (!ps2_clk_drive_low && t < WAIT_MAX) begin
         @(negedge clk);
         t++;
      end
      check("inhibit_seen", 32'(ps2_clk_drive_low), 1);
      while (ps2_clk_drive_low && !ps2_data_drive_low && inh < WAIT_MAX) begin
         @(negedge clk);
         inh++;
      end
      check("inhibit_len", 32'(inh >= INH), 1);
      check("start_under_inhibit", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 3);
      t = 0;
      while (ps2_clk_drive_low && t < WAIT_MAX) begin
         @(negedge clk);
         t++;
      end
      check("clk_released", 32'(ps2_clk_drive_low), 0);
      c0 = cyc;
      check("busy_flags", 32'({tx_ready, rx_inhibit}), 1);
      if (frame_q.size() == 0) begin
         check("frame_queued", 0, 1);
         return;
      end
      d       = frame_q.pop_front();
      exp_par = ($countones(d) % 2 == 0);
      if (silent) begin
         t = 0;
         while (!tx_error && t < TO + 100) begin
            @(negedge clk);
            t++;
         end
         check("timeout_len", 32'(cyc - c0), TO);
         check("timeout_release", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 0);
         return;
      end
      got    = '1;
      got[0] = ps2_data_in;
      for (int k = 1; k <= 11; k++) begin
         repeat (QTR) @(negedge clk);
         if (k == 11 && ack) dev_data = 1'b0;
         repeat (HALF - QTR) @(negedge clk);
         dev_clk = 1'b0;
         if (k == abort_fall) begin
            repeat (QTR) @(negedge clk);
            return;
         end
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         if (k <= 10) got[k] = ps2_data_in;
      end
      repeat (QTR) @(negedge clk);
      dev_data = 1'b1;
      check("start_bit", 32'(got[0]), 0);
      check("data_bits", 32'(got[8:1]), 32'(d));
      check("parity_bit", 32'(got[9]), 32'(exp_par));
      check("stop_bit", 32'(got[10]), 1);
   endtask

   task automatic finish_frame();
      int t = 0;
      while (done_q.size() != 0 && t < WAIT_MAX) begin
         @(negedge clk);
         t++;
      end
      check("outcome_seen", 32'(done_q.size()), 0);
      repeat (2) @(negedge clk);
      check("idle_after", 32'({tx_ready, rx_inhibit, ps2_clk_drive_low, ps2_data_drive_low}), 8);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_state",
            32'({ps2_clk_drive_low, ps2_data_drive_low, tx_ready, tx_done, tx_error, rx_inhibit}), 8);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      request(CMD_ENABLE, 1, 1'b0);
      device(1'b1, 1'b0, 0);
      finish_frame();

      request(CMD_SET_LEDS, 1, 1'b0);
      device(1'b1, 1'b0, 0);
      finish_frame();

      request(8'h5A, 0, 1'b0);
      device(1'b0, 1'b1, 0);
      finish_frame();

      request(8'hA5, 0, 1'b0);
      device(1'b0, 1'b0, 0);
      finish_frame();

      request(CMD_RESET, -1, 1'b0);
      device(1'b1, 1'b0, 5);
      rst = 1'b1;
      #1;
      check("reset_midframe",
            32'({ps2_clk_drive_low, ps2_data_drive_low, tx_ready, tx_done, tx_error, rx_inhibit}), 8);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      request(8'h00, 1, 1'b0);
      device(1'b1, 1'b0, 0);
      finish_frame();

      request(8'h12, 1, 1'b1);
      fork
         begin
            device(1'b1, 1'b0, 0);
            device(1'b1, 1'b0, 0);
         end
         begin : b2b_ctrl
            int t = 0;
            @(negedge clk);
            tx_data = 8'h34;
            frame_q.push_back(8'h34);
            done_q.push_back(1'b1);
            while (!tx_done && t < WAIT_MAX) begin
               @(negedge clk);
               t++;
            end
            @(negedge clk);
            check("b2b_ready_after_done", 32'(tx_ready), 1);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
         end
      join
      finish_frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard/mouse over the same two open-drain lines the keyboard receiver listens on.
- Runs the full host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, device acknowledge.
- Raises rx_inhibit while it owns the bus so the receive path ignores the frame.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before start (≥100 us; 5000 at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles from clock release to end of ack (15 ms at 50 MHz)
FILTER_MAX, 19, stable-count threshold for the input line filters (same value as the receive path)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ps2_clk_in  in  1  raw PS/2 clock pin level
ps2_data_in  in  1  raw PS/2 data pin level
ps2_clk_drive_low  out  1  1 = pull PS/2 clock low; 0 = release (pad is open-drain)
ps2_data_drive_low  out  1  1 = pull PS/2 data low; 0 = release
tx_data  in  8  byte to send
tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
tx_ready  out  1  1 only in IDLE
tx_done  out  1  one-cycle pulse: frame sent, device acked (data sampled 0 at ack edge)
tx_error  out  1  one-cycle pulse: timeout or missing ack (data sampled 1)
rx_inhibit  out  1  1 in every state except IDLE

Behaviour:
- Reset (async, rst=1): both drive_low=0 immediately, tx_ready=1, tx_done=0, tx_error=0, rx_inhibit=0; state IDLE; counters cleared. Reset mid-frame releases the bus at once; no pulse is emitted.
- Inputs pass through 2-flop sync + ps2_line_filter: the output follows the input only after FILTER_MAX+1 consecutive equal samples. Device falling edge = filtered clock 1->0, detected with one registered copy.
- Accept: in IDLE with tx_valid=1, latch tx_data, compute parity = ~^tx_data, build a 10-bit shift {stop=1, parity, data[7:0]}, go to INHIBIT next cycle. tx_data is ignored at all other times.
- INHIBIT: clk_drive_low=1, data_drive_low=0; count INHIBIT_CYCLES; then data_drive_low=1 (start bit) for one cycle with the clock still low; then clk_drive_low=0, clear edge count and timeout counter, go to SEND.
- SEND: on device falling edges 1..9, data_drive_low <= ~shift[0] and shift right. Falls 1-8 send data bits 0-7; fall 9 sends parity. Fall 10: data_drive_low=0 (stop bit = released) and go to ACK.
- ACK: on fall 11, sample filtered data. 0 -> WAIT_IDLE; 1 -> ERROR.
- WAIT_IDLE: wait until filtered clock=1 and filtered data=1, then pulse tx_done and go to IDLE.
- ERROR: release both lines, pulse tx_error one cycle, go to IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, count clk cycles; reaching TIMEOUT_CYCLES goes to ERROR. This covers a device that never clocks or a frame that stalls partway.
- tx_done and tx_error are never both 1 and never 1 in the same cycle as tx_ready-acceptance. tx_ready returns to 1 the cycle after the pulse.
- Edge count width: 4 bits. Timeout counter width: $clog2(TIMEOUT_CYCLES+1). Inhibit counter width: $clog2(INHIBIT_CYCLES+1).
- Falls beyond 11 while in WAIT_IDLE are ignored.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, ERROR), frame constants (DATA_BITS=8, STOP_FALL=10, ACK_FALL=11), common command byte constants (CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA).
- Sub-module ps2_line_filter (sync + stable-count filter, FILTER_MAX param), instantiated twice.

Test Plan:
- Device BFM clocks at 12.5 kHz and acks; send 0xF4 -> pins show start 0, data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses once; rx_inhibit=0 after.
- Send 0xED -> parity bit 1; tx_done pulses; clock held low ≥ INHIBIT_CYCLES before start is observed.
- Device never clocks after release -> tx_error pulses exactly TIMEOUT_CYCLES after clock release; both drive_low=0.
- BFM leaves data high at fall 11 -> tx_error pulses; no tx_done.
- Assert rst during fall 5 of a 0xFF frame -> both drive_low=0 in the same cycle; tx_ready=1; no pulse; next send of 0x00 (parity 1) completes normally.
- tx_valid held high with new tx_data during a frame -> second byte accepted only after tx_done; bytes sent back-to-back in order.
